eu_sdram_rd_arb: RTL and testbench

- Round-robin arbiter and sequencer for the single Avalon-MM SDRAM read master shared by the execution-unit groups (stmm and later groups).
- Grants one requester at a time and issues its burst read command.
- Steers readdatavalid to the owner, holds the grant until the last beat returns, then rotates priority.
- Also drives the mux select index consumed by the existing SDRAM read mux.

---
 rtl/eu_sdram_rd_arb.sv | 168 ++++++++++++++++
 tb/tb_eu_sdram_rd_arb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/eu_sdram_rd_arb.sv
// Round-robin arbiter/sequencer for the shared Avalon-MM SDRAM burst-read master.
// Optional watchdog abort enabled by defining EU_RD_ARB_TIMEOUT_EN.
module eu_sdram_rd_arb #(
   parameter int NUM_REQ     = 8,
   parameter int ADDR_W      = 32,
   parameter int BURST_W     = 8,
   parameter int TIMEOUT_CYC = 1024,
   localparam int SEL_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*BURST_W-1:0] req_burst,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [SEL_W-1:0]           sel,
   output logic [NUM_REQ-1:0]         rd_valid,
   output logic                       busy,
   output logic                       timeout_err,
   output logic [ADDR_W-1:0]          avm_address,
   output logic                       avm_read,
   output logic [BURST_W-1:0]         avm_burstcount,
   input  logic                       avm_waitrequest,
   input  logic                       avm_readdatavalid
);

   // state | meaning
   // IDLE  | no owner; arbitrate among req
   // CMD   | avm_read asserted, waiting for waitrequest low
   // DATA  | counting returned beats for the owner
   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [BURST_W-1:0]   burst_q, burst_d;
   logic [BURST_W-1:0]   cnt_q, cnt_d;

   logic                 found;
   logic [SEL_W-1:0]     pick;
   logic [SEL_W-1:0]     idx;
   logic [BURST_W-1:0]   pick_burst;

   // Search starts just past the last owner so it naturally gets lowest priority.
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr_q;
      idx   = rr_ptr_q;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = rr_ptr_q + SEL_W'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
      pick_burst = req_burst[int'(pick)*BURST_W +: BURST_W];
   end

`ifdef EU_RD_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            tmo_q, tmo_d;
`endif

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      sel_d    = sel_q;
      rr_ptr_d = rr_ptr_q;
      addr_d   = addr_q;
      burst_d  = burst_q;
      cnt_d    = cnt_q;
`ifdef EU_RD_ARB_TIMEOUT_EN
      wd_d     = '0;
      tmo_d    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d = ST_CMD;
               gnt_d   = NUM_REQ'(1) << pick;
               sel_d   = pick;
               addr_d  = req_addr[int'(pick)*ADDR_W +: ADDR_W];
               burst_d = (pick_burst == '0) ? BURST_W'(1) : pick_burst;
            end
         end
         ST_CMD: begin
            if (!avm_waitrequest) begin
               cnt_d   = burst_q;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (avm_readdatavalid) begin
               cnt_d = cnt_q - BURST_W'(1);
               if (cnt_q == BURST_W'(1)) begin
                  state_d  = ST_IDLE;
                  gnt_d    = '0;
                  rr_ptr_d = sel_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef EU_RD_ARB_TIMEOUT_EN
      // Watchdog restarts on every sign of progress; expiry overrides normal flow.
      if (state_q != ST_IDLE) begin
         if ((state_q == ST_CMD && !avm_waitrequest) ||
             (state_q == ST_DATA && avm_readdatavalid)) begin
            wd_d = '0;
         end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
            state_d  = ST_IDLE;
            gnt_d    = '0;
            rr_ptr_d = sel_q;
            tmo_d    = 1'b1;
         end else begin
            wd_d = wd_q + WD_W'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         sel_q    <= '0;
         rr_ptr_q <= '0;
         addr_q   <= '0;
         burst_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         sel_q    <= sel_d;
         rr_ptr_q <= rr_ptr_d;
         addr_q   <= addr_d;
         burst_q  <= burst_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef EU_RD_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q  <= '0;
         tmo_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         tmo_q <= tmo_d;
      end
   end
   assign timeout_err = tmo_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign gnt            = gnt_q;
   assign sel            = sel_q;
   assign busy           = (state_q != ST_IDLE);
   assign avm_read       = (state_q == ST_CMD);
   assign avm_address    = addr_q;
   assign avm_burstcount = burst_q;
   assign rd_valid       = (state_q == ST_DATA && avm_readdatavalid) ? gnt_q : '0;

endmodule

// File: tb/tb_eu_sdram_rd_arb.sv
// Directed bench for eu_sdram_rd_arb: grant timing, stall, round-robin, burst 0, reset, no-beat hang.
module tb_eu_sdram_rd_arb;
   localparam int NR = 8;
   localparam int AW = 32;
   localparam int BW = 8;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NR-1:0]       req = '0;
   logic [NR*AW-1:0]    req_addr = '0;
   logic [NR*BW-1:0]    req_burst = '0;
   logic [NR-1:0]       gnt;
   logic [2:0]          sel;
   logic [NR-1:0]       rd_valid;
   logic                busy;
   logic                timeout_err;
   logic [AW-1:0]       avm_address;
   logic                avm_read;
   logic [BW-1:0]       avm_burstcount;
   logic                avm_waitrequest = 1'b0;
   logic                avm_readdatavalid = 1'b0;

   int total_cnt = 0;
   int bad_cnt   = 0;

   eu_sdram_rd_arb #(
      .NUM_REQ(NR), .ADDR_W(AW), .BURST_W(BW), .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_burst(req_burst),
      .gnt(gnt), .sel(sel), .rd_valid(rd_valid), .busy(busy), .timeout_err(timeout_err),
      .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
      .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
      req_addr[i*AW +: AW]  = a;
      req_burst[i*BW +: BW] = b;
   endtask

   task automatic beats(input int n, input logic [NR-1:0] mask);
      for (int k = 0; k < n; k++) begin
         avm_readdatavalid = 1'b1;
         #1;
         check_eq("beat_rd_valid", rd_valid, mask);
         check_eq("beat_busy", busy, 1);
         tick();
      end
      avm_readdatavalid = 1'b0;
   endtask

   int exp_order[6] = '{0, 1, 3, 0, 1, 3};
   int tmo_seen;

   initial begin
      #2;
      check_eq("rst_gnt", gnt, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_read", avm_read, 0);
      check_eq("rst_sel", sel, 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // single request on port 0
      set_req(0, 32'h1000, 8'd4);
      req = 8'h01;
      tick();
      check_eq("s_gnt", gnt, 8'h01);
      check_eq("s_read", avm_read, 1);
      check_eq("s_addr", avm_address, 32'h1000);
      check_eq("s_burst", avm_burstcount, 4);
      req = 8'h00;
      tick();
      check_eq("s_read_drop", avm_read, 0);
      beats(4, 8'h01);
      check_eq("s_busy_end", busy, 0);
      check_eq("s_gnt_end", gnt, 0);

      // waitrequest stall for 5 cycles
      req = 8'h01;
      tick();
      req = 8'h00;
      for (int k = 0; k < 6; k++) begin
         avm_waitrequest = (k < 5);
         check_eq("w_read", avm_read, 1);
         check_eq("w_addr", avm_address, 32'h1000);
         check_eq("w_burst", avm_burstcount, 4);
         tick();
      end
      avm_waitrequest = 1'b0;
      check_eq("w_data_read", avm_read, 0);
      check_eq("w_data_busy", busy, 1);
      beats(4, 8'h01);
      check_eq("w_busy_end", busy, 0);

      // stray beat in IDLE, burst 0 on port 3, stray beat in CMD
      avm_readdatavalid = 1'b1;
      #1;
      check_eq("z_idle_stray", rd_valid, 0);
      tick();
      avm_readdatavalid = 1'b0;
      set_req(3, 32'h3000, 8'd0);
      req = 8'h08;
      tick();
      req = 8'h00;
      check_eq("z_gnt", gnt, 8'h08);
      check_eq("z_sel", sel, 3);
      check_eq("z_burst", avm_burstcount, 1);
      avm_readdatavalid = 1'b1;
      #1;
      check_eq("z_cmd_stray", rd_valid, 0);
      tick();
      avm_readdatavalid = 1'b0;
      beats(1, 8'h08);
      check_eq("z_busy_end", busy, 0);
      check_eq("z_sel_hold", sel, 3);

      // round robin on 0b1011, last owner was 3
      set_req(0, 32'h0100, 8'd2);
      set_req(1, 32'h0200, 8'd2);
      set_req(3, 32'h0400, 8'd2);
      req = 8'b0000_1011;
      for (int n = 0; n < 6; n++) begin
         tick();
         check_eq("rr_gnt", gnt, 8'h01 << exp_order[n]);
         check_eq("rr_sel", sel, exp_order[n]);
         tick();
         beats(2, 8'h01 << exp_order[n]);
      end
      req = 8'h00;
      tick();
      check_eq("rr_idle", busy, 0);

      // reset mid-DATA on port 5
      set_req(5, 32'h5000, 8'd8);
      req = 8'h20;
      tick();
      req = 8'h00;
      check_eq("r_gnt", gnt, 8'h20);
      tick();
      beats(2, 8'h20);
      rst_n = 1'b0;
      #1;
      check_eq("r_gnt0", gnt, 0);
      check_eq("r_read0", avm_read, 0);
      check_eq("r_busy0", busy, 0);
      check_eq("r_addr0", avm_address, 0);
      tick();
      rst_n = 1'b1;
      avm_readdatavalid = 1'b1;
      #1;
      check_eq("r_stray", rd_valid, 0);
      tick();
      avm_readdatavalid = 1'b0;
      set_req(2, 32'h2000, 8'd3);
      req = 8'h04;
      tick();
      req = 8'h00;
      check_eq("r2_gnt", gnt, 8'h04);
      check_eq("r2_sel", sel, 2);
      check_eq("r2_addr", avm_address, 32'h2000);
      tick();

      // command accepted, no beats come back
      tmo_seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (timeout_err) tmo_seen++;
         tick();
      end
`ifdef EU_RD_ARB_TIMEOUT_EN
      check_eq("t_pulses", tmo_seen, 1);
      check_eq("t_busy", busy, 0);
`else
      check_eq("t_pulses", tmo_seen, 0);
      check_eq("t_busy", busy, 1);
      check_eq("t_gnt", gnt, 8'h04);
`endif

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
